serial_pattern_tx: RTL
======================

Name: serial_pattern_tx

Overview:
Serial bit-stream transmitter. It is the driving end of the single-bit serial interface consumed by the team's sequence-detector FSMs.
- Accepts a parallel word over a valid/ready handshake.
- Shifts the word out MSB-first, one bit per clock, on a single-bit line with a qualifying valid strobe.
- Optionally repeats the word with idle gaps between copies.
- Used to drive detector inputs in-system and in benches.

Parameters:
WIDTH, 8, data bits per frame; legal range ≥2.
RPT_W, 4, width of the repeat-count field.
GAP_CYCLES, 2, idle cycles inserted between repeated frames; 0 means back-to-back frames.

Ports:
clk  input  1  clock, all state updated on rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  WIDTH  word to transmit, MSB sent first
data_valid  input  1  data_in and repeat_in are valid
data_ready  output  1  block can accept a word (high only in IDLE)
repeat_in  input  RPT_W  extra copies to send; total frames = repeat_in+1
out  output  1  serial data bit, registered
out_valid  output  1  out carries a frame bit this cycle, registered
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the final bit of the final frame

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clk.
- Reset values: state=IDLE, out=0, out_valid=0, done=0, busy=0, data_ready=1. All internal counters and registers are 0.
- State machine states: IDLE, SHIFT, GAP.
- data_ready is decoded combinationally from state==IDLE. busy is its complement.
- IDLE:
  - On a rising edge k with data_valid&&data_ready: capture data_in into the shift register and a reload copy, capture repeat_in into rpt_cnt, set bit_cnt=WIDTH-1, go to SHIFT.
  - data_valid while not ready is ignored. Inputs are not sampled.
- SHIFT:
  - Cycles k+1 .. k+WIDTH: out=current MSB, out_valid=1.
  - Shift left one bit per cycle. bit_cnt decrements.
  - Latency from acceptance to first bit is 1 cycle.
- End of frame (bit_cnt==0 in SHIFT):
  - If rpt_cnt>0: decrement rpt_cnt, reload the shift register from the copy. Then go to GAP if GAP_CYCLES>0; otherwise stay in SHIFT with no bubble.
  - Else: go to IDLE. done=1 for exactly one cycle, the cycle after the last bit. out_valid=0 and data_ready=1 in that same cycle.
- GAP:
  - out=0, out_valid=0 for exactly GAP_CYCLES cycles, then return to SHIFT.
  - The first bit of the next frame appears on the cycle after the last gap cycle.
- out is driven to 0 whenever out_valid=0.
- A new word can be accepted in the same cycle done is high. Minimum idle between transfers is 1 cycle.
- Changing data_in or repeat_in during a transfer has no effect.
- repeat_in = 2^RPT_W-1 is legal: 2^RPT_W frames are sent.
- Reset mid-operation: all outputs drop to reset values immediately. The in-flight word is discarded. No done pulse is produced.

Optional Feature:
Macro: SERIAL_PATTERN_TX_PARITY_EN
- Defined: each frame carries WIDTH+1 bits. The final bit is even parity, the XOR of the WIDTH data bits, with out_valid=1. done and the start of GAP shift one cycle later.
- Undefined: frames are exactly WIDTH bits and no parity logic is present.

Decomposition:
Shared package serial_tx_pkg contains:
- the state enum typedef (IDLE, SHIFT, GAP);
- a localparam/function for counter width: $clog2 of WIDTH+1 and of GAP_CYCLES+1, minimum 1.

The block is a single module. It needs no sub-module; the shift register, counters and FSM are all local.

Test Plan:
1. WIDTH=8, data_in=0xA5, repeat_in=0, accepted at edge k → out=1,0,1,0,0,1,0,1 on cycles k+1..k+8 with out_valid=1; done=1 and data_ready=1 at k+9 only.
2. WIDTH=3, data_in=3'b101, repeat_in=2, GAP_CYCLES=2 → three 101 frames, each separated by two cycles of out_valid=0; exactly one done pulse, after the third frame. When fed to the detector, it flags once per frame.
3. GAP_CYCLES=0, WIDTH=8, 0xF0, repeat_in=1 → 16 contiguous valid bits 11110000 11110000; done on cycle k+17.
4. Pulse data_valid with 0x3C while busy, and alter data_in mid-frame → data_ready=0 throughout; the transmitted stream is unchanged; the 0x3C word is not sent.
5. Assert reset during bit 4 of 0xA5 → out, out_valid and busy are 0 in the same cycle; after release data_ready=1; no done pulse appears.
6. With SERIAL_PATTERN_TX_PARITY_EN, 0xA5 (four ones) → ninth bit 0. With 0x07 (three ones) → ninth bit 1. done at k+10.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Width of a counter that must hold values 0..n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_pattern_tx.sv
// MSB-first serial transmitter with optional repeated frames separated by idle gaps.
// Define SERIAL_PATTERN_TX_PARITY_EN to append an even-parity bit to every frame.
//
// state | meaning
// IDLE  | waiting for a word, data_ready high
// SHIFT | one frame bit on out per cycle
// GAP   | idle cycles between repeated frames
module serial_pattern_tx
  import serial_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int RPT_W      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic [RPT_W-1:0] repeat_in,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int BIT_W = cnt_w(FLEN);
  localparam int GAP_W = cnt_w(GAP_CYCLES);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(FLEN - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  state_t            state, state_d;
  logic [FLEN-1:0]   sreg, sreg_d;
  logic [FLEN-1:0]   copy, copy_d;
  logic [BIT_W-1:0]  bit_cnt, bit_d;
  logic [RPT_W-1:0]  rpt_cnt, rpt_d;
  logic [GAP_W-1:0]  gap_cnt, gap_d;
  logic              done_d;
  logic [FLEN-1:0]   load_word;

  // Parity rides in the shift register as the last bit, so framing logic is shared.
`ifdef SERIAL_PATTERN_TX_PARITY_EN
  assign load_word = {data_in, ^data_in};
`else
  assign load_word = data_in;
`endif

  assign data_ready = (state == IDLE);
  assign busy       = ~data_ready;

  always_comb begin
    state_d = state;
    sreg_d  = sreg;
    copy_d  = copy;
    bit_d   = bit_cnt;
    rpt_d   = rpt_cnt;
    gap_d   = gap_cnt;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (data_valid) begin
          sreg_d  = load_word;
          copy_d  = load_word;
          rpt_d   = repeat_in;
          bit_d   = BIT_LOAD;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt == '0) begin
          if (rpt_cnt != '0) begin
            rpt_d  = rpt_cnt - RPT_W'(1);
            sreg_d = copy;
            bit_d  = BIT_LOAD;
            if (GAP_CYCLES > 0) begin
              state_d = GAP;
              gap_d   = GAP_LOAD;
            end
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          sreg_d = {sreg[FLEN-2:0], 1'b0};
          bit_d  = bit_cnt - BIT_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_d = SHIFT;
        else               gap_d   = gap_cnt - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so the first bit follows acceptance by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sreg      <= '0;
      copy      <= '0;
      bit_cnt   <= '0;
      rpt_cnt   <= '0;
      gap_cnt   <= '0;
      done      <= 1'b0;
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      sreg      <= sreg_d;
      copy      <= copy_d;
      bit_cnt   <= bit_d;
      rpt_cnt   <= rpt_d;
      gap_cnt   <= gap_d;
      done      <= done_d;
      out_valid <= (state_d == SHIFT);
      out       <= (state_d == SHIFT) & sreg_d[FLEN-1];
    end
  end

endmodule
